// File: rtl/regfile_multiport_pkg.sv
// rtl/regfile_multiport_pkg.sv - shared types and helpers for the multiport register file
package regfile_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int ZERO_REG_DEFAULT = 31;

    function automatic int addr_w(input int n_regs);
        return (n_regs <= 2) ? 1 : $clog2(n_regs);
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write port, read ports and busy flag of the register file
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int N_REGS = 32,
    parameter int N_RD   = 2
);
    localparam int AW = addr_w(N_REGS);

    logic                           we3;
    logic [AW-1:0]                  wa3;
    logic [DATA_W-1:0]              wd3;
    logic [N_RD-1:0][AW-1:0]        ra;
    logic [N_RD-1:0][DATA_W-1:0]    rd;
    logic                           busy;

    modport master (output we3, wa3, wd3, ra, input  rd, busy);
    modport slave  (input  we3, wa3, wd3, ra, output rd, busy);

endinterface

// File: rtl/regfile_multiport_init_seq.sv
// rtl/regfile_multiport_init_seq.sv - post-reset sweep sequencer loading Xi = i, one register per cycle
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int N_REGS = 32,
    localparam int AW    = addr_w(N_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          o_busy,
    output logic          o_init_we,
    output logic [AW-1:0] o_init_addr
);

    rf_state_t     r_state;
    rf_state_t     w_state_nxt;
    logic [AW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_cnt == AW'(N_REGS - 1)) begin
            w_state_nxt = READY;
        end
    end

    always_comb begin
        o_busy      = (r_state == INIT);
        o_init_we   = (r_state == INIT);
        o_init_addr = r_cnt;
    end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised register file, N_RD comb read ports, zero reg, optional REGFILE_MULTIPORT_BYPASS_EN
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int N_REGS   = 32,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = N_REGS - 1
) (
    input  logic                clk,
    input  logic                reset,
    regfile_multiport_if.slave  bus
);

    localparam int            AW     = addr_w(N_REGS);
    localparam logic [AW-1:0] ZR_IDX = AW'(ZERO_REG);

    logic [DATA_W-1:0]           r_mem [N_REGS];
    logic                        w_busy;
    logic                        w_init_we;
    logic [AW-1:0]               w_init_addr;
    logic [N_RD-1:0][DATA_W-1:0] w_rd;

    regfile_init_seq #(.N_REGS(N_REGS)) u_init_seq (
        .clk         (clk),
        .reset       (reset),
        .o_busy      (w_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr)
    );

    // The sweep owns the array while busy; the zero register is rewritten every sweep cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_init_we) begin
                r_mem[w_init_addr] <= DATA_W'(w_init_addr);
                r_mem[ZR_IDX]      <= '0;
            end else if (bus.we3 && bus.wa3 != ZR_IDX) begin
                r_mem[bus.wa3] <= bus.wd3;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (!w_busy && bus.ra[i] != ZR_IDX) begin
`ifdef REGFILE_MULTIPORT_BYPASS_EN
                if (bus.we3 && bus.wa3 == bus.ra[i]) begin
                    w_rd[i] = bus.wd3;
                end else begin
                    w_rd[i] = r_mem[bus.ra[i]];
                end
`else
                w_rd[i] = r_mem[bus.ra[i]];
`endif
            end
        end
    end

    assign bus.rd   = w_rd;
    assign bus.busy = w_busy;

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-cycle processor register file: configurable data width, register count and number of read ports.
- Adds an init sequencer. After reset it walks the array one register per cycle, loading Xi = i.
- Keeps the hardwired zero register. Used by the single-cycle core and the planned pipelined core, where a write-through bypass is optional.

Parameters:
DATA_W, 64, register width in bits
N_REGS, 32, number of architectural registers (power of two, >= 4)
N_RD, 2, number of combinational read ports (1..4)
ZERO_REG, N_REGS-1, index hardwired to 0 (X31/XZR)

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
we3  in  1  write enable
wa3  in  $clog2(N_REGS)  write address
wd3  in  DATA_W  write data
ra  in  N_RD x $clog2(N_REGS)  read addresses, one per port
rd  out  N_RD x DATA_W  read data, one per port
busy  out  1  high while the init sequencer runs

Behaviour:
- Sequencer states: INIT, READY.
- Reset (sampled at posedge):
  - state <= INIT, init counter <= 0, busy = 1 from the next cycle.
  - Array contents are not cleared in that cycle.
- INIT:
  - Each cycle: reg[cnt] <= cnt, zero-extended or truncated to DATA_W; reg[ZERO_REG] <= 0; cnt++.
  - When cnt == N_REGS-1 is written: state <= READY, busy <= 0.
  - INIT therefore lasts exactly N_REGS cycles after reset deasserts.
- During INIT:
  - we3 is ignored; no external write occurs.
  - All rd[i] = 0.
- READY:
  - If we3 && wa3 != ZERO_REG: reg[wa3] <= wd3 at posedge.
  - Writes to ZERO_REG are silently dropped.
- Reads are combinational: rd[i] = (ra[i] == ZERO_REG) ? 0 : reg[ra[i]]. Ports are independent; identical addresses on several ports are legal.
- Reset asserted mid-INIT: counter restarts at 0 and busy stays high. Full N_REGS-cycle sweep after reset deasserts.
- Reset asserted in READY: same; prior contents are overwritten by the sweep.
- Reset and we3 in the same cycle: reset wins, write discarded.
- No read/write port conflict exists: a single write port, and reads are combinational.
- busy reset value is 1. rd is 0 while busy.

Optional Feature:
- Macro: REGFILE_MULTIPORT_BYPASS_EN.
- Defined (for the pipelined core): in READY, if we3 && wa3 == ra[i] && wa3 != ZERO_REG, then rd[i] = wd3 in the same cycle, forwarding the write-through value. Priority per port: zero register > bypass > array.
- Not defined: rd[i] shows the old value until the posedge that commits the write.
- Bypass never applies during INIT.

Decomposition:
- Package regfile_pkg holds:
  - localparam AW = $clog2(N_REGS) helper function
  - typedef enum logic {INIT, READY} rf_state_t
  - default constant ZERO_REG_DEFAULT = 31
- One natural sub-module, regfile_init_seq: counter plus state flop, outputs busy, init_we, init_addr.
- Array and read muxing stay in the top module.

Test Plan:
- Reset for 2 cycles, then release → busy = 1 for exactly 32 cycles, then 0. Then ra = {5, 30} gives rd = {5, 30}, and ra = 31 gives rd = 0.
- During INIT: we3 = 1, wa3 = 3, wd3 = 0xAA → no effect. After busy falls, rd(ra = 3) = 3; all rd = 0 while busy.
- READY: write wa3 = 7, wd3 = 0xDEAD_BEEF → next cycle rd(ra = 7) = 0xDEADBEEF. Write wa3 = 31, wd3 = 5 → rd(ra = 31) stays 0.
- Reset pulsed at INIT cycle 10 → busy stays high 32 more cycles after release. Afterwards, X7 written earlier reads 7 again.
- With REGFILE_MULTIPORT_BYPASS_EN: we3 = 1, wa3 = 4, wd3 = 99, ra = {4, 4} → rd = {99, 99} in the same cycle.
- Without REGFILE_MULTIPORT_BYPASS_EN: same stimulus gives rd = {4, 4} before the edge and {99, 99} after it.
- N_RD = 4, DATA_W = 32 build: ra = {0, 1, 31, 31} → rd = {0, 1, 0, 0}. A write to register 2 appears on all ports reading 2.
